pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline. It drives stall (hold) and flush (bubble) controls for the F/D, D/E, E/M and M/W pipeline registers, including the E/M register that carries RegWrite, ResultSrc, MemWrite, ALUout, funct3, Rd, inc_PC and rs2. It also generates the E-stage forwarding selects and sequences variable-latency data-memory accesses with a wait FSM, a timeout and performance counters.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/fwd_unit.sv | 23 ++
 rtl/pipe_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and helpers for the 5-stage pipeline hazard controller.
// Holds the result-select, forward-select and memory FSM types.
package pipe_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } mem_state_t;

    // One bit per pipeline-register control driven by the controller.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } pipe_ctl_t;

    // A load in E whose destination feeds an operand of the instruction in D.
    function automatic logic load_use(input logic [1:0]           res_src_e,
                                      input logic [REG_IDX_W-1:0] rd_e,
                                      input logic [REG_IDX_W-1:0] rs1_d,
                                      input logic [REG_IDX_W-1:0] rs2_d);
        return (res_src_e == RES_MEM) && (rd_e != '0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for a single E-stage operand.
// The M-stage result is younger than W, so it wins when both match.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs_e,
    input  logic [REG_IDX_W-1:0] rd_m,
    input  logic [REG_IDX_W-1:0] rd_w,
    input  logic                 reg_write_m,
    input  logic                 reg_write_w,
    output logic [1:0]           fwd
);

    always_comb begin
        fwd = FWD_NONE;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller: stall/flush/forward generation plus a
// wait FSM for variable-latency data memory with timeout and perf counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] Rs1D,
    input  logic [REG_IDX_W-1:0] Rs2D,
    input  logic [REG_IDX_W-1:0] Rs1E,
    input  logic [REG_IDX_W-1:0] Rs2E,
    input  logic [REG_IDX_W-1:0] RdE,
    input  logic [REG_IDX_W-1:0] RdM,
    input  logic [REG_IDX_W-1:0] RdW,
    input  logic [1:0]           ResultSrcE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 mem_ready,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam int unsigned       WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    mem_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic              mem_stall;
    logic              lw_stall;
    logic              redirect;
    pipe_ctl_t         ctl;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cycles_q, flush_count_q;

    fwd_unit u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wait_inc   = wait_cnt_q + WAIT_W'(1);
        unique case (state_q)
            IDLE: begin
                if (MemReqM && !mem_ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= TIMEOUT_CNT) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // FSM and hazard outputs
    always_comb begin
        unique case (state_q)
            IDLE:    mem_stall = MemReqM && !mem_ready;
            WAIT:    mem_stall = !mem_ready;
            ERR:     mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase

        lw_stall = load_use(ResultSrcE, RdE, Rs1D, Rs2D);
        redirect = rst_n && !mem_stall && PCSrcE;
        ctl      = '0;

        if (!rst_n) begin
            ctl.flush_d = 1'b1;
            ctl.flush_e = 1'b1;
            ctl.flush_w = 1'b1;
        end else if (mem_stall) begin
            // E is held, so a pending redirect is still there after release.
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.stall_e = 1'b1;
            ctl.stall_m = 1'b1;
            ctl.flush_w = 1'b1;
        end else if (PCSrcE) begin
            ctl.flush_d = 1'b1;
            ctl.flush_e = 1'b1;
        end else if (lw_stall) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.flush_e = 1'b1;
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (ctl.stall_f) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (redirect) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign StallF       = ctl.stall_f;
    assign StallD       = ctl.stall_d;
    assign StallE       = ctl.stall_e;
    assign StallM       = ctl.stall_m;
    assign FlushD       = ctl.flush_d;
    assign FlushE       = ctl.flush_e;
    assign FlushW       = ctl.flush_w;
    assign ForwardAE    = rst_n ? fwd_a : FWD_NONE;
    assign ForwardBE    = rst_n ? fwd_b : FWD_NONE;
    assign mem_err      = (state_q == ERR);
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl, built with MEM_TIMEOUT=4.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, mem_ready;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        mem_err;
    logic [31:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rs1D         (Rs1D),
        .Rs2D         (Rs2D),
        .Rs1E         (Rs1E),
        .Rs2E         (Rs2E),
        .RdE          (RdE),
        .RdM          (RdM),
        .RdW          (RdW),
        .ResultSrcE   (ResultSrcE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .PCSrcE       (PCSrcE),
        .MemReqM      (MemReqM),
        .mem_ready    (mem_ready),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3; PCSrcE = 1'b1;
        #1;
        if ({FlushD, FlushE, FlushW} !== 3'b111) begin
            errors++; $display("FAIL reset_flush got=%b exp=111", {FlushD, FlushE, FlushW});
        end
        checks++;
        if ({StallF, StallD, StallE, StallM} !== 4'b0000) begin
            errors++; $display("FAIL reset_stall got=%b exp=0000", {StallF, StallD, StallE, StallM});
        end
        checks++;
        if (ForwardAE !== 2'b00) begin
            errors++; $display("FAIL reset_fwd got=%b exp=00", ForwardAE);
        end
        checks++;
        tick();
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%0d/%0d/%b exp=0/0/0", stall_cycles, flush_count, mem_err);
        end
        checks++;
        clear_inputs();
        rst_n = 1'b1;
        #1;
        if ({StallF, FlushD, FlushE, FlushW, StallM} !== 5'b00000) begin
            errors++; $display("FAIL idle_outputs got=%b exp=00000",
                               {StallF, FlushD, FlushE, FlushW, StallM});
        end
        checks++;
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
        #1;
        if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100) begin
            errors++; $display("FAIL load_use got=%b exp=11100", {StallF, StallD, FlushE, StallE, FlushD});
        end
        checks++;
        tick();
        clear_inputs();
        #1;
        if (stall_cycles !== 32'd1) begin
            errors++; $display("FAIL load_use_count got=%0d exp=1", stall_cycles);
        end
        checks++;
        if (StallF !== 1'b0) begin
            errors++; $display("FAIL load_use_release got=%b exp=0", StallF);
        end
        checks++;
        // Match through rs2 only
        ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd1; Rs2D = 5'd9;
        #1;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            errors++; $display("FAIL load_use_rs2 got=%b exp=111", {StallF, StallD, FlushE});
        end
        checks++;
        ResultSrcE = 2'b00;
        #1;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            errors++; $display("FAIL alu_no_stall got=%b exp=000", {StallF, StallD, FlushE});
        end
        checks++;
        clear_inputs();
    endtask

    task automatic test_forward();
        do_reset();
        RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7;
        #1;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_prio got=%b/%b exp=10/10", ForwardAE, ForwardBE);
        end
        checks++;
        RdM = 5'd3;
        #1;
        if (ForwardAE !== 2'b01) begin
            errors++; $display("FAIL fwd_wb got=%b exp=01", ForwardAE);
        end
        checks++;
        RdM = 5'd7; RegWriteM = 1'b0; Rs2E = 5'd4; RdW = 5'd4;
        #1;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b01) begin
            errors++; $display("FAIL fwd_split got=%b/%b exp=00/01", ForwardAE, ForwardBE);
        end
        checks++;
        RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; Rs1D = 5'd0; ResultSrcE = 2'b01;
        #1;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
            errors++; $display("FAIL fwd_x0 got=%b/%b exp=00/00", ForwardAE, ForwardBE);
        end
        checks++;
        if (StallF !== 1'b0) begin
            errors++; $display("FAIL x0_no_lwstall got=%b exp=0", StallF);
        end
        checks++;
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        MemReqM = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b1111100) begin
                errors++; $display("FAIL mem_wait_c%0d got=%b exp=1111100", i,
                                   {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE});
            end
            checks++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if ({StallM, FlushW, StallF} !== 3'b000) begin
            errors++; $display("FAIL mem_release got=%b exp=000", {StallM, FlushW, StallF});
        end
        checks++;
        tick();
        MemReqM = 1'b0; mem_ready = 1'b0;
        #1;
        if (stall_cycles !== 32'd3) begin
            errors++; $display("FAIL mem_wait_count got=%0d exp=3", stall_cycles);
        end
        checks++;
        if (StallM !== 1'b0) begin
            errors++; $display("FAIL mem_back_idle got=%b exp=0", StallM);
        end
        checks++;
        // Single-cycle access: ready in the same cycle never stalls
        MemReqM = 1'b1; mem_ready = 1'b1;
        #1;
        if (StallM !== 1'b0) begin
            errors++; $display("FAIL mem_single got=%b exp=0", StallM);
        end
        checks++;
        clear_inputs();
    endtask

    task automatic test_redirect_wait();
        do_reset();
        MemReqM = 1'b1; mem_ready = 1'b0; PCSrcE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            if ({FlushD, FlushE, StallF} !== 3'b001) begin
                errors++; $display("FAIL redir_wait_c%0d got=%b exp=001", i, {FlushD, FlushE, StallF});
            end
            checks++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if ({FlushD, FlushE, StallF} !== 3'b110) begin
            errors++; $display("FAIL redir_release got=%b exp=110", {FlushD, FlushE, StallF});
        end
        checks++;
        tick();
        clear_inputs();
        #1;
        if (flush_count !== 32'd1 || stall_cycles !== 32'd2) begin
            errors++; $display("FAIL redir_wait_counts got=%0d/%0d exp=1/2", flush_count, stall_cycles);
        end
        checks++;
    endtask

    task automatic test_redirect_load_use();
        do_reset();
        PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5;
        #1;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
            errors++; $display("FAIL redir_lw got=%b exp=1100", {FlushD, FlushE, StallF, StallD});
        end
        checks++;
        tick();
        clear_inputs();
        #1;
        if (flush_count !== 32'd1 || stall_cycles !== 32'd0) begin
            errors++; $display("FAIL redir_lw_counts got=%0d/%0d exp=1/0", flush_count, stall_cycles);
        end
        checks++;
    endtask

    task automatic test_timeout();
        do_reset();
        MemReqM = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        if (mem_err !== 1'b0) begin
            errors++; $display("FAIL timeout_early got=%b exp=0", mem_err);
        end
        checks++;
        tick();
        if (mem_err !== 1'b1 || StallM !== 1'b1) begin
            errors++; $display("FAIL timeout_err got=%b/%b exp=1/1", mem_err, StallM);
        end
        checks++;
        // ERR ignores ready and redirects
        MemReqM = 1'b0; mem_ready = 1'b1; PCSrcE = 1'b1;
        #1;
        if ({StallF, StallM, FlushW, FlushD} !== 4'b1110) begin
            errors++; $display("FAIL err_hold got=%b exp=1110", {StallF, StallM, FlushW, FlushD});
        end
        checks++;
        tick();
        if (stall_cycles !== 32'd5 || flush_count !== 32'd0 || mem_err !== 1'b1) begin
            errors++; $display("FAIL err_counts got=%0d/%0d/%b exp=5/0/1",
                               stall_cycles, flush_count, mem_err);
        end
        checks++;
        rst_n = 1'b0;
        #1;
        if ({StallF, FlushD, FlushE, FlushW} !== 4'b0111) begin
            errors++; $display("FAIL err_in_reset got=%b exp=0111", {StallF, FlushD, FlushE, FlushW});
        end
        checks++;
        tick();
        rst_n = 1'b1;
        clear_inputs();
        #1;
        if (mem_err !== 1'b0 || stall_cycles !== 32'd0 || flush_count !== 32'd0 || StallF !== 1'b0) begin
            errors++; $display("FAIL err_recover got=%b/%0d/%0d/%b exp=0/0/0/0",
                               mem_err, stall_cycles, flush_count, StallF);
        end
        checks++;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_redirect_wait();
        test_redirect_load_use();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
